// File: rtl/clkmon_pkg.sv
// ============================================================================
// Module : clkmon_pkg
// Brief  : Shared FSM state type, nominal timing constants and tolerance helper
// Rev    : 1.0
// ============================================================================
`default_nettype none

package clkmon_pkg;

    typedef enum logic [1:0] {
        ACQ   = 2'd0,
        TRACK = 2'd1,
        LOCK  = 2'd2
    } state_e;

    localparam int unsigned PERIOD2_NOM = 10000;
    localparam int unsigned HALF_EXP    = PERIOD2_NOM / 2;

    // Unsigned distance test; operands are zero-extended by the caller.
    function automatic logic in_tol(input logic [63:0] meas,
                                    input logic [63:0] exp_v,
                                    input logic [63:0] tol);
        logic [63:0] diff;
        diff = (meas >= exp_v) ? (meas - exp_v) : (exp_v - meas);
        return (diff <= tol);
    endfunction

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// ============================================================================
// Module : sync_2ff
// Brief  : 1-bit two-flop synchroniser, asynchronous active-low reset
// Rev    : 1.0
// ============================================================================
`default_nettype none

module sync_2ff (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

`default_nettype wire

// File: rtl/clk_div_monitor.sv
// ============================================================================
// Module : clk_div_monitor
// Brief  : Samples a divided clock, strobes its edges, measures half-periods
//          and reports lock / sticky error status.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module clk_div_monitor
    import clkmon_pkg::*;
#(
    parameter int unsigned PERIOD2  = 2 * HALF_EXP,
    parameter int unsigned TOL      = 2,
    parameter int unsigned LOCK_CNT = 4,
    parameter int unsigned CNT_W    = 25
) (
    input  logic             clk_in1,
    input  logic             rst_n,
    input  logic             clk_mon,
    input  logic             clr_err,
    output logic             rise_pulse,
    output logic             fall_pulse,
    output logic             meas_valid,
    output logic [CNT_W-1:0] half_cnt,
    output logic             locked,
    output logic             err
);

    localparam int unsigned      HALF_P    = PERIOD2 / 2;
    localparam int unsigned      RUN_W     = $clog2(LOCK_CNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W:0]   TIMEOUT_V = (CNT_W + 1)'(PERIOD2);
    localparam logic [RUN_W-1:0] RUN_FULL  = RUN_W'(LOCK_CNT);

    generate
        if (64'(PERIOD2) >= (64'd1 << CNT_W)) begin : g_chk_width
            $error("clk_div_monitor: PERIOD2 does not fit in CNT_W bits");
        end
        if ((PERIOD2 < 4) || (PERIOD2 % 2 != 0)) begin : g_chk_period
            $error("clk_div_monitor: PERIOD2 must be even and at least 4");
        end
        if (LOCK_CNT < 1) begin : g_chk_lock
            $error("clk_div_monitor: LOCK_CNT must be at least 1");
        end
    endgenerate

    logic             mon_sync;
    logic             prev_q;
    logic             edge_det;
    state_e           state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic [RUN_W-1:0] run_q,    run_d;
    logic [CNT_W-1:0] half_q,   half_d;
    logic             rise_q,   rise_d;
    logic             fall_q,   fall_d;
    logic             mv_q,     mv_d;
    logic             locked_q, locked_d;
    logic             err_q,    err_d;
    logic [CNT_W:0]   meas;
    logic             good;
    logic             timeout;
    logic             set_err;

    sync_2ff u_sync (
        .clk_i  (clk_in1),
        .rst_ni (rst_n),
        .d_i    (clk_mon),
        .q_o    (mon_sync)
    );

    assign edge_det = mon_sync ^ prev_q;
    // One extra bit keeps cnt+1 exact even when cnt sits at its ceiling.
    assign meas     = {1'b0, cnt_q} + (CNT_W + 1)'(1);
    assign good     = in_tol(64'(meas), 64'(HALF_P), 64'(TOL));
    assign timeout  = !edge_det && (state_q != ACQ) && (meas == TIMEOUT_V);

    always_comb begin
        state_d  = state_q;
        cnt_d    = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        run_d    = run_q;
        half_d   = half_q;
        rise_d   = edge_det & mon_sync;
        fall_d   = edge_det & ~mon_sync;
        mv_d     = 1'b0;
        locked_d = locked_q;
        set_err  = 1'b0;

        if (edge_det) begin
            cnt_d = '0;
            if (state_q == ACQ) begin
                // The first edge closes a partial half-period; only restart timing.
                state_d = TRACK;
            end else begin
                mv_d   = 1'b1;
                half_d = meas[CNT_W-1:0];
                if (good) begin
                    if (run_q != RUN_FULL) begin
                        run_d = run_q + RUN_W'(1);
                    end
                    if (run_d == RUN_FULL) begin
                        state_d  = LOCK;
                        locked_d = 1'b1;
                    end
                end else begin
                    set_err  = 1'b1;
                    run_d    = '0;
                    locked_d = 1'b0;
                    state_d  = TRACK;
                end
            end
        end else if (timeout) begin
            set_err  = 1'b1;
            run_d    = '0;
            locked_d = 1'b0;
            state_d  = ACQ;
        end

        err_d = err_q;
        if (clr_err) begin
            err_d = 1'b0;
        end
        if (set_err) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in1 or negedge rst_n) begin
        if (!rst_n) begin
            prev_q   <= 1'b0;
            state_q  <= ACQ;
            cnt_q    <= '0;
            run_q    <= '0;
            half_q   <= '0;
            rise_q   <= 1'b0;
            fall_q   <= 1'b0;
            mv_q     <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            prev_q   <= mon_sync;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            run_q    <= run_d;
            half_q   <= half_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            mv_q     <= mv_d;
            locked_q <= locked_d;
            err_q    <= err_d;
        end
    end

    assign rise_pulse = rise_q;
    assign fall_pulse = fall_q;
    assign meas_valid = mv_q;
    assign half_cnt   = half_q;
    assign locked     = locked_q;
    assign err        = err_q;

endmodule

`default_nettype wire
